// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller: 1 s prescaler, phase FSM, registered BCD countdowns, night blink.
// Optional pedestrian shortening of main green is enabled by defining TRAFFIC_PED_EN.
module traffic_ctrl_param #(
  parameter int CLK_DIV   = 50000000,
  parameter int GREEN_A   = 30,
  parameter int GREEN_B   = 20,
  parameter int YELLOW    = 3,
  parameter int CLEAR     = 1,
  parameter int PED_SHORT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       night,
  input  logic       ped_req,
  output logic [2:0] LAMP_A,
  output logic [2:0] LAMP_B,
  output logic [3:0] COUNT_A_H,
  output logic [3:0] COUNT_A_L,
  output logic [3:0] COUNT_B_H,
  output logic [3:0] COUNT_B_L,
  output logic       tick
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be at least 2");
  end
  if (CLEAR < 1) begin : g_bad_clear
    $error("CLEAR must be at least 1");
  end
  if (GREEN_A < 1 || GREEN_B < 1 || YELLOW < 1) begin : g_bad_dur
    $error("green and yellow durations must be at least 1");
  end
  if (GREEN_A + YELLOW + CLEAR > 99) begin : g_bad_sum_a
    $error("GREEN_A+YELLOW+CLEAR exceeds two BCD digits");
  end
  if (GREEN_B + YELLOW + CLEAR > 99) begin : g_bad_sum_b
    $error("GREEN_B+YELLOW+CLEAR exceeds two BCD digits");
  end

  localparam int            PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);
  localparam logic [6:0]    D_GA   = 7'(GREEN_A);
  localparam logic [6:0]    D_GB   = 7'(GREEN_B);
  localparam logic [6:0]    D_Y    = 7'(YELLOW);
  localparam logic [6:0]    D_C    = 7'(CLEAR);
  localparam logic [6:0]    D_PS   = 7'(PED_SHORT);

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [2:0] {AG, AY, CLR1, BG, BY, CLR2, NIGHT} state_t;

  state_t        state_q;
  logic [6:0]    rem_q;
  logic          blink_q;
  logic [2:0]    lamp_a_q, lamp_b_q;
  logic [PW-1:0] ps_q;
  logic [7:0]    bcd_a_q, bcd_b_q;
  logic [6:0]    cnt_a_d, cnt_b_d;
  logic          ped_hit;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Prescaler: tick is the wrap cycle itself, so the FSM acts on the same edge.
  assign tick = EN && (ps_q == PS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ps_q <= '0;
    else if (EN) ps_q <= tick ? '0 : ps_q + PW'(1);
  end

`ifdef TRAFFIC_PED_EN
  assign ped_hit = ped_req && (state_q == AG) && (rem_q > D_PS);
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AG;
      rem_q    <= D_GA;
      blink_q  <= 1'b0;
      lamp_a_q <= L_G;
      lamp_b_q <= L_R;
    end else if (EN) begin
      if (tick && night) begin
        // Blink starts lit on entry, then toggles on every further tick.
        state_q  <= NIGHT;
        rem_q    <= '0;
        blink_q  <= (state_q == NIGHT) ? ~blink_q : 1'b1;
        lamp_a_q <= (state_q == NIGHT && blink_q) ? L_OFF : L_Y;
        lamp_b_q <= (state_q == NIGHT && blink_q) ? L_OFF : L_Y;
      end else if (tick && state_q == NIGHT) begin
        state_q  <= AG;
        rem_q    <= D_GA;
        blink_q  <= 1'b0;
        lamp_a_q <= L_G;
        lamp_b_q <= L_R;
      end else if (tick && rem_q == 7'd1) begin
        case (state_q)
          AG:      begin state_q <= AY;   rem_q <= D_Y;  lamp_a_q <= L_Y; lamp_b_q <= L_R; end
          AY:      begin state_q <= CLR1; rem_q <= D_C;  lamp_a_q <= L_R; lamp_b_q <= L_R; end
          CLR1:    begin state_q <= BG;   rem_q <= D_GB; lamp_a_q <= L_R; lamp_b_q <= L_G; end
          BG:      begin state_q <= BY;   rem_q <= D_Y;  lamp_a_q <= L_R; lamp_b_q <= L_Y; end
          BY:      begin state_q <= CLR2; rem_q <= D_C;  lamp_a_q <= L_R; lamp_b_q <= L_R; end
          default: begin state_q <= AG;   rem_q <= D_GA; lamp_a_q <= L_G; lamp_b_q <= L_R; end
        endcase
      end else if (ped_hit) begin
        rem_q <= D_PS;
      end else if (tick) begin
        rem_q <= rem_q - 7'd1;
      end
    end
  end

  // Seconds until each road's lamp next changes, summed over the phases that keep it unchanged.
  always_comb begin
    cnt_a_d = rem_q;
    cnt_b_d = rem_q;
    case (state_q)
      AG:      cnt_b_d = rem_q + D_Y + D_C;
      AY:      cnt_b_d = rem_q + D_C;
      CLR1:    cnt_a_d = rem_q + D_GB + D_Y + D_C;
      BG:      cnt_a_d = rem_q + D_Y + D_C;
      BY:      cnt_a_d = rem_q + D_C;
      CLR2:    cnt_b_d = rem_q + D_GA + D_Y + D_C;
      NIGHT:   begin cnt_a_d = '0; cnt_b_d = '0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_a_q <= to_bcd(D_GA);
      bcd_b_q <= to_bcd(D_GA + D_Y + D_C);
    end else begin
      bcd_a_q <= to_bcd(cnt_a_d);
      bcd_b_q <= to_bcd(cnt_b_d);
    end
  end

  assign LAMP_A    = lamp_a_q;
  assign LAMP_B    = lamp_b_q;
  assign COUNT_A_H = bcd_a_q[7:4];
  assign COUNT_A_L = bcd_a_q[3:0];
  assign COUNT_B_H = bcd_b_q[7:4];
  assign COUNT_B_L = bcd_b_q[3:0];

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: vector table after reset, hand sequences, random run vs phase-schedule model.
module tb_traffic_ctrl_param;
  localparam int CLK_DIV = 4, GA = 5, GB = 3, YL = 2, CL = 1, PS = 2;
`ifdef TRAFFIC_PED_EN
  localparam bit PED_BUILD = 1'b1;
`else
  localparam bit PED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, EN, night, ped_req;
  logic [2:0] LAMP_A, LAMP_B;
  logic [3:0] COUNT_A_H, COUNT_A_L, COUNT_B_H, COUNT_B_L;
  logic tick;
  int n_tests = 0, n_fail = 0;

  traffic_ctrl_param #(.CLK_DIV(CLK_DIV), .GREEN_A(GA), .GREEN_B(GB), .YELLOW(YL),
                       .CLEAR(CL), .PED_SHORT(PS)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .night(night), .ped_req(ped_req),
    .LAMP_A(LAMP_A), .LAMP_B(LAMP_B),
    .COUNT_A_H(COUNT_A_H), .COUNT_A_L(COUNT_A_L),
    .COUNT_B_H(COUNT_B_H), .COUNT_B_L(COUNT_B_L), .tick(tick));

  always #5 clk = ~clk;

  // Reference model: phase index into the fixed 6-phase schedule plus seconds left in it.
  int m_ph, m_rem, m_ps;
  bit m_night, m_blink;

  function automatic int dur(int p);
    int d;
    case (p)
      0:       d = GA;
      1, 4:    d = YL;
      3:       d = GB;
      default: d = CL;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] lamp_of(int p, bit road_a);
    if (road_a) return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] m_lamp(bit road_a);
    if (m_night) return m_blink ? 3'b010 : 3'b000;
    return lamp_of(m_ph, road_a);
  endfunction

  // Walk forward through the schedule until this road's lamp differs.
  function automatic int until_change(bit road_a);
    int s, p;
    logic [2:0] cur;
    if (m_night) return 0;
    s = m_rem;
    p = m_ph;
    cur = lamp_of(p, road_a);
    for (int k = 0; k < 6; k++) begin
      p = (p + 1) % 6;
      if (lamp_of(p, road_a) != cur) return s;
      s += dur(p);
    end
    return s;
  endfunction

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = GA; m_ps = 0; m_night = 1'b0; m_blink = 1'b0;
  endtask

  task automatic model_step(bit en, bit nt, bit pr);
    bit t;
    if (!en) return;
    t = (m_ps == CLK_DIV - 1);
    m_ps = t ? 0 : m_ps + 1;
    if (t && nt) begin
      m_blink = m_night ? !m_blink : 1'b1;
      m_night = 1'b1;
    end else if (t && m_night) begin
      m_night = 1'b0; m_ph = 0; m_rem = GA;
    end else if (t && m_rem == 1) begin
      m_ph = (m_ph + 1) % 6; m_rem = dur(m_ph);
    end else if (PED_BUILD && pr && !m_night && m_ph == 0 && m_rem > PS) begin
      m_rem = PS;
    end else if (t) begin
      m_rem = m_rem - 1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock, entered and left at a falling edge.
  task automatic cycle(bit en, bit nt, bit pr);
    logic [7:0] pa, pb;
    EN = en; night = nt; ped_req = pr;
    #1;
    chk("tick", {31'd0, tick}, {31'd0, (en && m_ps == CLK_DIV - 1)});
    pa = bcd(until_change(1'b1));
    pb = bcd(until_change(1'b0));
    @(posedge clk);
    model_step(en, nt, pr);
    @(negedge clk);
    chk("lamp_a", {29'd0, LAMP_A}, {29'd0, m_lamp(1'b1)});
    chk("lamp_b", {29'd0, LAMP_B}, {29'd0, m_lamp(1'b0)});
    chk("count_a", {24'd0, COUNT_A_H, COUNT_A_L}, {24'd0, pa});
    chk("count_b", {24'd0, COUNT_B_H, COUNT_B_L}, {24'd0, pb});
  endtask

  task automatic run_to(int ph);
    for (int i = 0; i < 200 && !(m_ph == ph && !m_night); i++) cycle(1'b1, 1'b0, 1'b0);
    chk("reach_b", {29'd0, LAMP_B}, {29'd0, lamp_of(ph, 1'b0)});
  endtask

  task automatic check_reset_vals(string nm);
    chk({nm, "_lamp_a"}, {29'd0, LAMP_A}, 32'h1);
    chk({nm, "_lamp_b"}, {29'd0, LAMP_B}, 32'h4);
    chk({nm, "_count_a"}, {24'd0, COUNT_A_H, COUNT_A_L}, 32'h05);
    chk({nm, "_count_b"}, {24'd0, COUNT_B_H, COUNT_B_L}, 32'h08);
    chk({nm, "_tick"}, {31'd0, tick}, 32'h0);
  endtask

  typedef struct {
    int         edge_n;
    logic [2:0] la, lb;
    logic [7:0] ca, cb;
  } vec_t;
  vec_t vt[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit nt;
    int idx;
    // Edge numbers counted from reset release; counts show the state one edge earlier.
    vt[0] = '{1,  3'b001, 3'b100, 8'h05, 8'h08};
    vt[1] = '{4,  3'b001, 3'b100, 8'h05, 8'h08};
    vt[2] = '{5,  3'b001, 3'b100, 8'h04, 8'h07};
    vt[3] = '{20, 3'b010, 3'b100, 8'h01, 8'h04};
    vt[4] = '{21, 3'b010, 3'b100, 8'h02, 8'h03};
    vt[5] = '{29, 3'b100, 3'b100, 8'h07, 8'h01};
    vt[6] = '{33, 3'b100, 3'b001, 8'h06, 8'h03};
    vt[7] = '{45, 3'b100, 3'b010, 8'h03, 8'h02};
    vt[8] = '{53, 3'b100, 3'b100, 8'h01, 8'h09};
    vt[9] = '{57, 3'b001, 3'b100, 8'h05, 8'h08};

    rst_n = 1'b0; EN = 1'b1; night = 1'b0; ped_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    idx = 0;
    for (int e = 1; e <= 57; e++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (idx < 10 && vt[idx].edge_n == e) begin
        chk($sformatf("vec%0d_lamp_a", idx), {29'd0, LAMP_A}, {29'd0, vt[idx].la});
        chk($sformatf("vec%0d_lamp_b", idx), {29'd0, LAMP_B}, {29'd0, vt[idx].lb});
        chk($sformatf("vec%0d_count_a", idx), {24'd0, COUNT_A_H, COUNT_A_L}, {24'd0, vt[idx].ca});
        chk($sformatf("vec%0d_count_b", idx), {24'd0, COUNT_B_H, COUNT_B_L}, {24'd0, vt[idx].cb});
        idx++;
      end
    end

    // Freeze during BG with the prescaler mid-count.
    run_to(3);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    repeat (12) cycle(1'b1, 1'b0, 1'b0);

    // Night entered from BY, held for several ticks, then released.
    run_to(4);
    repeat (18) cycle(1'b1, 1'b1, 1'b0);
    chk("night_count_a", {24'd0, COUNT_A_H, COUNT_A_L}, 32'h00);
    chk("night_count_b", {24'd0, COUNT_B_H, COUNT_B_L}, 32'h00);
    repeat (10) cycle(1'b1, 1'b0, 1'b0);

    // Asynchronous reset asserted between edges during BY.
    run_to(4);
    cycle(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midby_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TRAFFIC_PED_EN
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("ped_short", {24'd0, COUNT_A_H, COUNT_A_L}, 32'h02);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
`endif

    nt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) nt = !nt;
      cycle($urandom_range(0, 7) != 0, nt, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_ctrl_param.md
TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clk cycles per one-second tick, minimum 2.
REQ-002 Parameter GREEN_A, default 30: main-road green time in seconds.
REQ-003 Parameter GREEN_B, default 20: secondary-road green time in seconds.
REQ-004 Parameter YELLOW, default 3: yellow time in seconds, both roads.
REQ-005 Parameter CLEAR, default 1: all-red clearance time in seconds, minimum 1.
REQ-006 Parameter PED_SHORT, default 5: main green remaining time forced by a pedestrian request, in seconds.
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 EN  input  1  run enable; 0 freezes all timing.
REQ-010 night  input  1  night mode request, level-sensitive.
REQ-011 ped_req  input  1  pedestrian request, one-cycle pulse.
REQ-012 LAMP_A  output  3  main lamps {R,Y,G}, registered.
REQ-013 LAMP_B  output  3  secondary lamps {R,Y,G}, registered.
REQ-014 COUNT_A_H, COUNT_A_L  output  4 each  BCD seconds until LAMP_A next changes.
REQ-015 COUNT_B_H, COUNT_B_L  output  4 each  BCD seconds until LAMP_B next changes.
REQ-016 tick  output  1  one-cycle pulse at each one-second boundary.

Function
REQ-017 Prescaler SHALL count 0..CLK_DIV-1 while EN=1, assert tick on the cycle it wraps, and hold its value while EN=0.
REQ-018 FSM states SHALL be AG, AY, CLR1, BG, BY, CLR2, NIGHT, with cyclic order AG->AY->CLR1->BG->BY->CLR2->AG.
REQ-019 Lamps SHALL be: AG A=G B=R; AY A=Y B=R; CLR1/CLR2 A=R B=R; BG A=R B=G; BY A=R B=Y.
REQ-020 Remaining counter rem SHALL load the state duration on entry and decrement on tick; tick with rem=1 SHALL advance the state.
REQ-021 COUNT_A SHALL be: rem in AG/AY; rem+GREEN_B+YELLOW+CLEAR in CLR1; rem+YELLOW+CLEAR in BG; rem+CLEAR in BY; rem in CLR2.
REQ-022 COUNT_B SHALL be: rem+YELLOW+CLEAR in AG; rem+CLEAR in AY; rem in CLR1/BG/BY; rem+GREEN_A+YELLOW+CLEAR in CLR2.
REQ-023 Binary-to-BCD conversion SHALL be registered and SHALL add exactly one cycle of latency relative to rem.
REQ-024 Durations SHALL satisfy GREEN_A+YELLOW+CLEAR <= 99 and GREEN_B+YELLOW+CLEAR <= 99; elaboration SHALL fail otherwise.
REQ-025 night=1 sampled on any tick SHALL enter NIGHT: both lamps Y toggling each tick, starting on; all counts 0.
REQ-026 night=0 sampled on a tick in NIGHT SHALL enter AG with rem=GREEN_A.
REQ-027 EN=0 SHALL hold state, rem, lamps and counts; EN=0 SHALL also mask ped_req.
REQ-028 A tick coinciding with an AG->AY transition SHALL take priority over ped_req in the same cycle.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state AG, rem=GREEN_A, prescaler=0, tick=0, LAMP_A=001, LAMP_B=100.
REQ-030 During reset the count outputs SHALL be: COUNT_A={GREEN_A BCD}; COUNT_B={(GREEN_A+YELLOW+CLEAR) BCD}.
REQ-031 Reset released mid-cycle SHALL restart a full GREEN_A period; no prior state SHALL be retained.

Configuration
REQ-032 Macro TRAFFIC_PED_EN defined: ped_req in AG with rem>PED_SHORT SHALL set rem=PED_SHORT on the next clk; it SHALL be ignored in other states or when rem<=PED_SHORT.
REQ-033 Macro TRAFFIC_PED_EN undefined: ped_req SHALL be unused and the timing SHALL be identical to a design with ped_req tied 0.

Verification (CLK_DIV=4, GREEN_A=5, GREEN_B=3, YELLOW=2, CLEAR=1, PED_SHORT=2)
REQ-034 Reset then EN=1 -> AG 5 ticks, AY 2, CLR1 1, BG 3, BY 2, CLR2 1; cycle repeats every 14 ticks (56 clk).
REQ-035 In AG with rem=5 -> COUNT_A=05, COUNT_B=08; in CLR1 with rem=1 -> COUNT_A=07, COUNT_B=01.
REQ-036 With TRAFFIC_PED_EN, ped_req at AG rem=4 -> rem=2, AY begins 2 ticks later; ped_req at rem=2 -> no change.
REQ-037 EN=0 for 20 clk during BG -> lamps, counts and tick frozen; resumes with the same remaining prescaler phase.
REQ-038 night=1 during BY -> NIGHT at next tick, both Y blink 1010..., counts 00; night=0 -> AG, COUNT_A=05.
REQ-039 rst_n low mid-BY -> immediate LAMP_A=001, LAMP_B=100, COUNT_A=05, COUNT_B=08.
